// File: rtl/capture_pkg.sv
// capture_pkg: shared constants and FSM state type for the capture sequencer
package capture_pkg;
  localparam int CAP_NCH = 8;
  localparam int CAP_DW = 14;
  typedef enum logic [2:0] {IDLE, SYNC, PRIME, CAPTURE, DRAIN} cap_state_t;
endpackage

// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: serialised sample stream; CAPTURE_SEQ_HEADER_EN adds O_hdr
interface capture_sequencer_if #(parameter int DW = 14);
  logic [DW-1:0] O_dout;
  logic [2:0] O_chan;
  logic O_valid;
  logic I_ready;
`ifdef CAPTURE_SEQ_HEADER_EN
  logic O_hdr;
`endif
  modport master(output O_dout, O_chan, O_valid, input I_ready
`ifdef CAPTURE_SEQ_HEADER_EN
    , output O_hdr
`endif
  );
  modport slave(input O_dout, O_chan, O_valid, output I_ready
`ifdef CAPTURE_SEQ_HEADER_EN
    , input O_hdr
`endif
  );
endinterface

// File: rtl/frame_serializer.sv
// frame_serializer: one-frame buffer emitted ch0..ch7 on valid/ready; CAPTURE_SEQ_HEADER_EN prepends a frame-index beat
module frame_serializer
  import capture_pkg::*;
#(
  parameter int NCH = CAP_NCH,
  parameter int DW = CAP_DW
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              clr,
  input  logic              load,
  input  logic [NCH*DW-1:0] din,
`ifdef CAPTURE_SEQ_HEADER_EN
  input  logic [DW-1:0]     fidx,
`endif
  output logic              full,
  output logic              last_acc,
  capture_sequencer_if.master s
);
`ifdef CAPTURE_SEQ_HEADER_EN
  localparam int LAST = NCH;
  logic [DW-1:0] hdr_q;
  logic [2:0] ch;
`else
  localparam int LAST = NCH - 1;
`endif
  logic [NCH*DW-1:0] buf_q;
  logic [3:0] idx_q;
  logic full_q;
  assign full = full_q;
  assign last_acc = full_q & s.I_ready & (idx_q == 4'(LAST));
  assign s.O_valid = full_q;
`ifdef CAPTURE_SEQ_HEADER_EN
  // beat 0 is the header, so data beat b carries channel b-1
  assign ch = idx_q[2:0] - 3'd1;
  assign s.O_dout = (idx_q == 4'd0) ? hdr_q : buf_q[ch*DW +: DW];
  assign s.O_chan = (idx_q == 4'd0) ? 3'd0 : ch;
  assign s.O_hdr = full_q & (idx_q == 4'd0);
`else
  assign s.O_dout = buf_q[idx_q[2:0]*DW +: DW];
  assign s.O_chan = idx_q[2:0];
`endif
  always_ff @(posedge I_clk or posedge I_rst)
    if (I_rst) begin
      buf_q <= '0;
      idx_q <= '0;
      full_q <= 1'b0;
`ifdef CAPTURE_SEQ_HEADER_EN
      hdr_q <= '0;
`endif
    end else if (clr) begin
      idx_q <= '0;
      full_q <= 1'b0;
    end else if (load) begin
      buf_q <= din;
      idx_q <= '0;
      full_q <= 1'b1;
`ifdef CAPTURE_SEQ_HEADER_EN
      hdr_q <= fidx;
`endif
    end else if (last_acc) begin
      idx_q <= '0;
      full_q <= 1'b0;
    end else if (full_q && s.I_ready) begin
      idx_q <= idx_q + 4'd1;
    end
endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: decimator run control (sync, prime, capture N frames, drain); CAPTURE_SEQ_HEADER_EN adds frame headers
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int NCH = CAP_NCH,
  parameter int DW = CAP_DW
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_start,
  input  logic              I_abort,
  input  logic [15:0]       I_nframes,
  input  logic              I_rdy,
  input  logic [NCH*DW-1:0] I_din,
  output logic              O_dec_rst,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_overrun,
  capture_sequencer_if.master out
);
  cap_state_t state_q, state_d;
  logic [15:0] cnt_q, nfr_q;
  logic ovr_q, zero_q, load, full, last_acc, can_take;
  // the buffer counts as free in the cycle its last beat is accepted
  assign can_take = !full || last_acc;
  assign O_dec_rst = state_q == SYNC;
  assign O_busy = state_q != IDLE;
  assign O_overrun = ovr_q;
  assign O_done = zero_q | (state_q == DRAIN && !full && !I_abort);
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    case (state_q)
      IDLE: state_d = (I_start && I_nframes != '0) ? SYNC : IDLE;
      SYNC: state_d = PRIME;
      PRIME: state_d = I_rdy ? CAPTURE : PRIME;
      CAPTURE: begin
        load = I_rdy && can_take;
        state_d = (load && cnt_q + 16'd1 == nfr_q) ? DRAIN : CAPTURE;
      end
      DRAIN: state_d = full ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
    if (I_abort) begin
      state_d = IDLE;
      load = 1'b0;
    end
  end
  always_ff @(posedge I_clk or posedge I_rst)
    if (I_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      nfr_q <= '0;
      ovr_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zero_q <= state_q == IDLE && I_start && I_nframes == '0 && !I_abort;
      if (state_q == IDLE && I_start) nfr_q <= I_nframes;
      if (state_q == SYNC) begin
        cnt_q <= '0;
        ovr_q <= 1'b0;
      end
      if (load) cnt_q <= cnt_q + 16'd1;
      if (state_q == CAPTURE && I_rdy && !can_take && !I_abort) ovr_q <= 1'b1;
    end
  frame_serializer #(.NCH(NCH), .DW(DW)) u_ser (
    .I_clk(I_clk),
    .I_rst(I_rst),
    .clr(I_abort),
    .load(load),
    .din(I_din),
`ifdef CAPTURE_SEQ_HEADER_EN
    .fidx(cnt_q[DW-1:0]),
`endif
    .full(full),
    .last_acc(last_acc),
    .s(out)
  );
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed self-checking bench for capture_sequencer (either CAPTURE_SEQ_HEADER_EN build)
module tb_capture_sequencer;
  import capture_pkg::*;
  localparam int NCH = CAP_NCH;
  localparam int DW = CAP_DW;
`ifdef CAPTURE_SEQ_HEADER_EN
  localparam int NB = NCH + 1;
`else
  localparam int NB = NCH;
`endif
  logic I_clk = 1'b0, I_rst = 1'b1, I_start = 1'b0, I_abort = 1'b0, I_rdy = 1'b0;
  logic [15:0] I_nframes = '0;
  logic [NCH*DW-1:0] I_din = '0;
  logic O_dec_rst, O_busy, O_done, O_overrun;
  int checks = 0, failures = 0;
  capture_sequencer_if #(.DW(DW)) s();
  capture_sequencer #(.NCH(NCH), .DW(DW)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_abort(I_abort),
    .I_nframes(I_nframes), .I_rdy(I_rdy), .I_din(I_din), .O_dec_rst(O_dec_rst),
    .O_busy(O_busy), .O_done(O_done), .O_overrun(O_overrun), .out(s)
  );
  always #5 I_clk = ~I_clk;
  task automatic tick;
    @(posedge I_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [NCH*DW-1:0] mk(input int base);
    logic [NCH*DW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction
  function automatic int edout(input int base, input int fidx, input int b);
`ifdef CAPTURE_SEQ_HEADER_EN
    return (b == 0) ? fidx : base + b - 1;
`else
    return base + b + 0 * fidx;
`endif
  endfunction
  function automatic int echan(input int b);
`ifdef CAPTURE_SEQ_HEADER_EN
    return (b == 0) ? 0 : b - 1;
`else
    return b;
`endif
  endfunction
  task automatic rdy_pulse(input int base);
    I_din = mk(base);
    I_rdy = 1'b1;
    tick;
    I_rdy = 1'b0;
  endtask
  task automatic start(input int n);
    I_nframes = 16'(n);
    I_start = 1'b1;
    tick;
    I_start = 1'b0;
  endtask
  task automatic beats(input int base, input int fidx, input int b0, input int b1,
                       input bit rdy_last, input int nxt);
    for (int b = b0; b <= b1; b++) begin
      chk("beat_valid", 32'(s.O_valid), 1);
      chk("beat_dout", 32'(s.O_dout), edout(base, fidx, b));
      chk("beat_chan", 32'(s.O_chan), echan(b));
`ifdef CAPTURE_SEQ_HEADER_EN
      chk("beat_hdr", 32'(s.O_hdr), 32'(b == 0));
`endif
      if (rdy_last && b == NB - 1) begin
        I_din = mk(nxt);
        I_rdy = 1'b1;
      end
      tick;
      I_rdy = 1'b0;
    end
  endtask
  initial begin
    s.I_ready = 1'b1;
    repeat (3) tick;
    I_rst = 1'b0;
    tick;
    chk("rst_dec_rst", 32'(O_dec_rst), 0);
    chk("rst_dout", 32'(s.O_dout), 0);
    chk("rst_chan", 32'(s.O_chan), 0);
    chk("rst_valid", 32'(s.O_valid), 0);
    chk("rst_busy", 32'(O_busy), 0);
    chk("rst_done", 32'(O_done), 0);
    chk("rst_overrun", 32'(O_overrun), 0);
    // two frames, second strobe lands on the last beat of the first
    start(2);
    chk("sync_busy", 32'(O_busy), 1);
    chk("sync_dec_rst", 32'(O_dec_rst), 1);
    tick;
    chk("prime_dec_rst", 32'(O_dec_rst), 0);
    rdy_pulse('hF00);
    chk("prime_dropped", 32'(s.O_valid), 0);
    rdy_pulse('h100);
    beats('h100, 0, 0, NB - 1, 1'b1, 'h110);
    beats('h110, 1, 0, NB - 1, 1'b0, 0);
    chk("run1_done", 32'(O_done), 1);
    chk("run1_busy_hold", 32'(O_busy), 1);
    tick;
    chk("run1_done_end", 32'(O_done), 0);
    chk("run1_busy_end", 32'(O_busy), 0);
    chk("run1_overrun", 32'(O_overrun), 0);
    // zero-frame request
    start(0);
    chk("zero_done", 32'(O_done), 1);
    chk("zero_busy", 32'(O_busy), 0);
    chk("zero_dec_rst", 32'(O_dec_rst), 0);
    chk("zero_valid", 32'(s.O_valid), 0);
    tick;
    chk("zero_done_end", 32'(O_done), 0);
    // stall mid-frame long enough to drop a frame
    start(3);
    tick;
    rdy_pulse('hF00);
    rdy_pulse('h100);
    beats('h100, 0, 0, 1, 1'b0, 0);
    s.I_ready = 1'b0;
    repeat (50) tick;
    chk("stall_no_ovr", 32'(O_overrun), 0);
    rdy_pulse('h1A0);
    chk("stall_ovr", 32'(O_overrun), 1);
    repeat (150) tick;
    chk("stall_valid", 32'(s.O_valid), 1);
    chk("stall_dout", 32'(s.O_dout), edout('h100, 0, 2));
    chk("stall_chan", 32'(s.O_chan), echan(2));
    s.I_ready = 1'b1;
    beats('h100, 0, 2, NB - 1, 1'b0, 0);
    chk("ovr_idle_busy", 32'(O_busy), 1);
    chk("ovr_idle_valid", 32'(s.O_valid), 0);
    repeat (3) tick;
    rdy_pulse('h110);
    beats('h110, 1, 0, NB - 1, 1'b0, 0);
    repeat (3) tick;
    rdy_pulse('h120);
    beats('h120, 2, 0, NB - 1, 1'b0, 0);
    chk("ovr_done", 32'(O_done), 1);
    chk("ovr_sticky", 32'(O_overrun), 1);
    tick;
    chk("ovr_busy_end", 32'(O_busy), 0);
    // abort while a beat is on the stream
    start(2);
    tick;
    rdy_pulse('hF00);
    rdy_pulse('h300);
    chk("abort_pre_valid", 32'(s.O_valid), 1);
    I_abort = 1'b1;
    tick;
    I_abort = 1'b0;
    chk("abort_valid", 32'(s.O_valid), 0);
    chk("abort_busy", 32'(O_busy), 0);
    chk("abort_done", 32'(O_done), 0);
    chk("abort_ovr", 32'(O_overrun), 0);
    tick;
    chk("abort_done_late", 32'(O_done), 0);
    start(1);
    chk("rerun_dec_rst", 32'(O_dec_rst), 1);
    tick;
    rdy_pulse('hF00);
    rdy_pulse('h200);
    beats('h200, 0, 0, NB - 1, 1'b0, 0);
    chk("rerun_done", 32'(O_done), 1);
    tick;
    chk("rerun_busy_end", 32'(O_busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
